// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU control codes, opcodes, result-source selects
// and the decoded control bundle passed from ID into the ID/EX register.
package pipe_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Bit 3 flags a supported funct3; the low bits carry the ALU code.
  function automatic logic [3:0] alu_map(input logic [2:0] funct3);
    case (funct3)
      3'b000:  alu_map = {1'b1, ALU_ADD};
      3'b010:  alu_map = {1'b1, ALU_SLT};
      3'b100:  alu_map = {1'b1, ALU_XOR};
      3'b110:  alu_map = {1'b1, ALU_OR};
      3'b111:  alu_map = {1'b1, ALU_AND};
      default: alu_map = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_decoder.sv
// Combinational ID-stage decoder: opcode/funct3/funct7b5 into the ALU control
// bundle. Unsupported encodings raise illegal with every side effect cleared.
module alu_issue_decoder
  import pipe_pkg::*;
(
  input  logic [6:0] op_d,
  input  logic [2:0] funct3_d,
  input  logic       funct7b5_d,
  output ctrl_t      ctrl_d
);

  logic [3:0] map;

  always_comb begin
    ctrl_d = '0;
    map    = alu_map(funct3_d);
    case (op_d)
      OP_RTYPE: begin
        if (map[3]) begin
          ctrl_d.alu_control = (funct3_d == 3'b000 && funct7b5_d) ? ALU_SUB : map[2:0];
          ctrl_d.reg_write   = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_IALU: begin
        if (map[3]) begin
          ctrl_d.alu_control = map[2:0];
          ctrl_d.alu_src     = 1'b1;
          ctrl_d.reg_write   = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3_d == 3'b010) begin
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.result_src = RES_MEM;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3_d == 3'b010) begin
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.mem_write = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3_d == 3'b000) begin
          ctrl_d.alu_control = ALU_SUB;
          ctrl_d.branch      = 1'b1;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU path: decodes in ID, registers controls
// and operands, with reset > flush > stall > load priority.
module id_ex_alu_issue
  import pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic [6:0]            op_d,
  input  logic [2:0]            funct3_d,
  input  logic                  funct7b5_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  output logic                  valid_e,
  output logic [2:0]            alu_control_e,
  output logic                  alu_src_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic [1:0]            result_src_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  illegal_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [REG_ADDR_W-1:0] rd_e
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_e;

  alu_issue_decoder u_decoder (
    .op_d       (op_d),
    .funct3_d   (funct3_d),
    .funct7b5_d (funct7b5_d),
    .ctrl_d     (ctrl_d)
  );

  // A load with no valid instruction in ID inserts the same bubble as a flush.
  always_ff @(posedge clk) begin
    if (rst || flush_e || (!stall_e && !valid_d)) begin
      valid_e   <= 1'b0;
      ctrl_e    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_ext_e <= '0;
      pc_e      <= '0;
      rd_e      <= '0;
    end else if (!stall_e) begin
      valid_e   <= 1'b1;
      ctrl_e    <= ctrl_d;
      rd1_e     <= rd1_d;
      rd2_e     <= rd2_d;
      imm_ext_e <= imm_ext_d;
      pc_e      <= pc_d;
      rd_e      <= rd_d;
    end
  end

  assign alu_control_e = ctrl_e.alu_control;
  assign alu_src_e     = ctrl_e.alu_src;
  assign reg_write_e   = ctrl_e.reg_write;
  assign mem_write_e   = ctrl_e.mem_write;
  assign result_src_e  = ctrl_e.result_src;
  assign branch_e      = ctrl_e.branch;
  assign jump_e        = ctrl_e.jump;
  assign illegal_e     = ctrl_e.illegal;

endmodule
